// File: rtl/sgd_layer_update.sv
// Weight/bias registers of one fully-connected layer with a serial
// SGD sweep: each element p <= sat(p - ((lr*g) >>> FRAC_W)), one per clock.
//
// state  | meaning
// IDLE   | accepts loads and start
// UPD_W  | updates W[idx], row-major
// UPD_B  | updates b[idx]
// DONE   | raises done for one cycle, then returns to IDLE
module sgd_layer_update #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load_en,
  input  logic [$clog2(ROWS*COLS+ROWS)-1:0]    load_addr,
  input  logic [DATA_W-1:0]                    load_data,
  input  logic                                 start,
  input  logic [DATA_W-1:0]                    lr,
  input  logic [ROWS*COLS*DATA_W-1:0]          dW_flat,
  input  logic [ROWS*DATA_W-1:0]               db_flat,
  output logic [ROWS*COLS*DATA_W-1:0]          W_flat,
  output logic [ROWS*DATA_W-1:0]               b_flat,
  output logic                                 busy,
  output logic                                 done
);

  localparam int NW = ROWS * COLS;
  localparam int NB = ROWS;
  localparam int IW = $clog2(NW + NB);
  localparam logic signed [2*DATA_W:0] MAXV = (2*DATA_W+1)'((2**(DATA_W-1)) - 1);
  localparam logic signed [2*DATA_W:0] MINV = -(2*DATA_W+1)'(2**(DATA_W-1));
  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, UPD_W, UPD_B, DONE} state_t;

  state_t                    state;
  logic [IW-1:0]             idx;
  logic signed [DATA_W-1:0]  lr_q;
  logic signed [DATA_W-1:0]  w_mem [NW];
  logic signed [DATA_W-1:0]  b_mem [NB];

  logic signed [DATA_W-1:0]   p;
  logic signed [DATA_W-1:0]   g;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] step;
  logic signed [2*DATA_W:0]   diff;
  logic signed [DATA_W-1:0]   res;

  // Select the element under update; the datapath is shared by W and b.
  always_comb begin
    p = '0;
    g = '0;
    for (int i = 0; i < NW; i++) begin
      if (state == UPD_W && int'(idx) == i) begin
        p = w_mem[i];
        g = dW_flat[i*DATA_W +: DATA_W];
      end
    end
    for (int j = 0; j < NB; j++) begin
      if (state == UPD_B && int'(idx) == j) begin
        p = b_mem[j];
        g = db_flat[j*DATA_W +: DATA_W];
      end
    end
    prod = lr_q * g;
    step = prod >>> FRAC_W;
    diff = (2*DATA_W+1)'(p) - (2*DATA_W+1)'(step);
    if (diff > MAXV)
      res = SMAX;
    else if (diff < MINV)
      res = SMIN;
    else
      res = diff[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      lr_q  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NW; i++) w_mem[i] <= '0;
      for (int j = 0; j < NB; j++) b_mem[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lr_q  <= lr;
            idx   <= '0;
            busy  <= 1'b1;
            state <= UPD_W;
          end else if (load_en) begin
            for (int i = 0; i < NW; i++)
              if (int'(load_addr) == i) w_mem[i] <= load_data;
            for (int j = 0; j < NB; j++)
              if (int'(load_addr) == NW + j) b_mem[j] <= load_data;
          end
        end
        UPD_W: begin
          for (int i = 0; i < NW; i++)
            if (int'(idx) == i) w_mem[i] <= res;
          if (idx == IW'(NW - 1)) begin
            idx   <= '0;
            state <= UPD_B;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        UPD_B: begin
          for (int j = 0; j < NB; j++)
            if (int'(idx) == j) b_mem[j] <= res;
          if (idx == IW'(NB - 1)) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle raises done; the second drops it and frees the block.
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NW; i++) begin : g_wflat
    assign W_flat[i*DATA_W +: DATA_W] = w_mem[i];
  end
  for (genvar j = 0; j < NB; j++) begin : g_bflat
    assign b_flat[j*DATA_W +: DATA_W] = b_mem[j];
  end

endmodule

// File: tb/tb_sgd_layer_update.sv
// Directed bench for sgd_layer_update: expected end-of-sweep contents are
// queued at start and compared by a monitor whenever done pulses.
module tb_sgd_layer_update;

  localparam int ROWS = 4, COLS = 4, DW = 16, NW = 16, NB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            load_en;
  logic [4:0]      load_addr;
  logic [DW-1:0]   load_data;
  logic            start;
  logic [DW-1:0]   lr;
  logic [NW*DW-1:0] dW_flat;
  logic [NB*DW-1:0] db_flat;
  logic [NW*DW-1:0] W_flat;
  logic [NB*DW-1:0] b_flat;
  logic            busy;
  logic            done;

  sgd_layer_update #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .FRAC_W(8)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .lr(lr), .dW_flat(dW_flat),
    .db_flat(db_flat), .W_flat(W_flat), .b_flat(b_flat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW*DW-1:0] w;
    logic [NB*DW-1:0] b;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  logic [DW-1:0]  w_exp [NW];
  logic [DW-1:0]  b_exp [NB];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NW*DW-1:0] pack_w();
    logic [NW*DW-1:0] f;
    for (int i = 0; i < NW; i++) f[i*DW +: DW] = w_exp[i];
    return f;
  endfunction

  function automatic logic [NB*DW-1:0] pack_b();
    logic [NB*DW-1:0] f;
    for (int j = 0; j < NB; j++) f[j*DW +: DW] = b_exp[j];
    return f;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.w = pack_w();
    e.b = pack_b();
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [DW-1:0] data);
    load_en = 1'b1; load_addr = 5'(addr); load_data = data;
    tick(1);
    load_en = 1'b0;
    if (addr < NW) w_exp[addr] = data;
    else if (addr < NW + NB) b_exp[addr-NW] = data;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin tick(1); n++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  function automatic logic [DW-1:0] wv(input int i);
    return W_flat[i*DW +: DW];
  endfunction

  // Monitor: every done pulse retires one queued expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_done: got done=1 expected no pending sweep");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_W", 256'(W_flat), 256'(e.w));
        check("sb_b", 256'(b_flat), 256'(e.b));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_en = 0; load_addr = 0; load_data = 0; start = 0;
    lr = 0; dW_flat = '0; db_flat = '0;
    for (int i = 0; i < NW; i++) w_exp[i] = '0;
    for (int j = 0; j < NB; j++) b_exp[j] = '0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_W", 256'(W_flat), 256'(0));
    check("rst_b", 256'(b_flat), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));

    load(0, 16'h0100); load(1, 16'h7F00); load(2, 16'h8100);
    load(3, 16'h0005); load(4, 16'h0005); load(16, 16'h0100);
    check("load_W", 256'(W_flat), 256'(pack_w()));
    check("load_b", 256'(b_flat), 256'(pack_b()));

    // Sweep A: 1.0 - 0.5*0.5 = 0.75; b0 1.0 - 0.5*1.0 = 0.5
    dW_flat = '0; dW_flat[0 +: DW] = 16'h0080;
    db_flat = '0; db_flat[0 +: DW] = 16'h0100;
    lr = 16'h0080;
    w_exp[0] = 16'h00C0; b_exp[0] = 16'h0080;
    push_exp();
    start = 1'b1; tick(1); start = 1'b0;
    check("a_busy_k", 256'(busy), 256'(1));
    check("a_w0_k", 256'(wv(0)), 256'(16'h0100));
    tick(1);
    check("a_w0_k1", 256'(wv(0)), 256'(16'h00C0));
    check("a_w1_k1", 256'(wv(1)), 256'(16'h7F00));
    wait_idle("a_idle");

    // Sweep B: saturation both ways, b3 = 0 - 1.0, timing and ignored pulses
    dW_flat = '0; dW_flat[1*DW +: DW] = 16'h8000; dW_flat[2*DW +: DW] = 16'h7FFF;
    db_flat = '0; db_flat[3*DW +: DW] = 16'h0100;
    lr = 16'h0100;
    w_exp[1] = 16'h7FFF; w_exp[2] = 16'h8000; b_exp[3] = 16'hFF00;
    push_exp();
    start = 1'b1; tick(1); start = 1'b0;
    check("b_busy_k", 256'(busy), 256'(1));
    lr = 16'h7FFF;
    tick(4);
    start = 1'b1; load_en = 1'b1; load_addr = 5'd5; load_data = 16'h1234;
    tick(1);
    start = 1'b0; load_en = 1'b0;
    tick(4);
    start = 1'b1; tick(1); start = 1'b0;
    tick(9);
    check("b_b3_k19", 256'(b_flat[3*DW +: DW]), 256'(16'h0000));
    tick(1);
    check("b_b3_k20", 256'(b_flat[3*DW +: DW]), 256'(16'hFF00));
    check("b_done_k20", 256'(done), 256'(0));
    tick(1);
    check("b_done_k21", 256'(done), 256'(1));
    check("b_busy_k21", 256'(busy), 256'(1));
    tick(1);
    check("b_done_k22", 256'(done), 256'(0));
    check("b_busy_k22", 256'(busy), 256'(0));
    check("b_w5_busy_load", 256'(wv(5)), 256'(16'h0000));

    // Out-of-range load must not touch anything
    load_en = 1'b1; load_addr = 5'd20; load_data = 16'h7777; tick(1); load_en = 1'b0;
    check("oor_W", 256'(W_flat), 256'(pack_w()));
    check("oor_b", 256'(b_flat), 256'(pack_b()));

    // Sweep C: floor of tiny steps; start+load same cycle drops the load
    dW_flat = '0; dW_flat[3*DW +: DW] = 16'h0001; dW_flat[4*DW +: DW] = 16'hFFFF;
    db_flat = '0;
    lr = 16'h0001;
    w_exp[4] = 16'h0006;
    push_exp();
    start = 1'b1; load_en = 1'b1; load_addr = 5'd6; load_data = 16'h5555;
    tick(1);
    start = 1'b0; load_en = 1'b0;
    check("c_busy_k", 256'(busy), 256'(1));
    wait_idle("c_idle");
    check("c_w6_dropped", 256'(wv(6)), 256'(16'h0000));

    // Sweep D: reset at edge k+7 aborts everything
    dW_flat = '0; dW_flat[0 +: DW] = 16'h0100;
    lr = 16'h0100;
    start = 1'b1; tick(1); start = 1'b0;
    tick(6);
    reset = 1'b1; tick(1); reset = 1'b0;
    for (int i = 0; i < NW; i++) w_exp[i] = '0;
    for (int j = 0; j < NB; j++) b_exp[j] = '0;
    check("d_rst_W", 256'(W_flat), 256'(0));
    check("d_rst_b", 256'(b_flat), 256'(0));
    check("d_rst_busy", 256'(busy), 256'(0));
    check("d_rst_done", 256'(done), 256'(0));
    tick(1);
    check("d_rst_busy2", 256'(busy), 256'(0));

    // Sweep E: full sweep again from idx 0
    load(15, 16'h0200);
    dW_flat = '0; dW_flat[0 +: DW] = 16'h0080; dW_flat[15*DW +: DW] = 16'h0100;
    db_flat = '0;
    lr = 16'h0100;
    w_exp[0] = 16'hFF80; w_exp[15] = 16'h0100;
    push_exp();
    start = 1'b1; tick(1); start = 1'b0;
    tick(1);
    check("e_w0_k1", 256'(wv(0)), 256'(16'hFF80));
    tick(14);
    check("e_w15_k15", 256'(wv(15)), 256'(16'h0200));
    tick(1);
    check("e_w15_k16", 256'(wv(15)), 256'(16'h0100));
    wait_idle("e_idle");

    tick(3);
    check("sb_empty", 256'(sb.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sgd_layer_update.md
Name: sgd_layer_update

Overview:
Weight/bias storage and gradient-descent update for one fully-connected layer. It consumes the dW and db gradients produced by the backward pass and applies W <= W - lr*dW and b <= b - lr*db serially, one element per clock. It holds the layer's W and b registers and presents them flat to the forward and backward nets. One instance is used per layer (L2xL1, L3xL2, L4xL3).

Parameters:
ROWS, 4, output neurons of the layer (matrix rows, bias length)
COLS, 4, input neurons of the layer (matrix columns)
DATA_W, 16, signed fixed-point word width (matches data_type)
FRAC_W, 8, fractional bits (Q8.8 by default)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
load_en  input  1  write one W/b element from the load port (IDLE only)
load_addr  input  clog2(ROWS*COLS+ROWS)  0..ROWS*COLS-1 = W row-major; ROWS*COLS+j = b[j]
load_data  input  DATA_W  value written on load
start  input  1  begin an update sweep (one-cycle pulse, IDLE only)
lr  input  DATA_W  learning rate, Q format, captured on start
dW_flat  input  ROWS*COLS*DATA_W  gradient, element [r][c] at index r*COLS+c
db_flat  input  ROWS*DATA_W  bias gradient
W_flat  output  ROWS*COLS*DATA_W  current weights, same packing as dW_flat
b_flat  output  ROWS*DATA_W  current biases
busy  output  1  sweep in progress
done  output  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (synchronous, active-high; overrides all inputs, including mid-sweep): all W and b = 0, busy = 0, done = 0, state = IDLE, index = 0, captured lr = 0.
- FSM states: IDLE, UPD_W, UPD_B, DONE.
  - IDLE: if start, capture lr, set idx = 0, go to UPD_W. Else, if load_en, write load_data at load_addr; out-of-range addresses are ignored.
  - If start and load_en are asserted in the same cycle, start wins and the load is dropped.
  - UPD_W: each cycle update W[idx], idx++. After idx = ROWS*COLS-1, set idx = 0 and go to UPD_B.
  - UPD_B: each cycle update b[idx], idx++. After idx = ROWS-1, go to DONE.
  - DONE: done = 1 for exactly one cycle, then go to IDLE.
- busy = 1 in UPD_W, UPD_B and DONE; busy = 0 in IDLE. Both outputs are registered from state.
- Timing: with start sampled at edge k:
  - W element i is written at edge k+1+i.
  - b[j] is written at edge k+1+ROWS*COLS+j.
  - done is high during the cycle after edge k+ROWS*COLS+ROWS+1, and the block is back in IDLE one edge later.
  - Total sweep length is ROWS*COLS+ROWS+1 cycles.
- start and load_en are ignored while busy = 1.
- dW_flat and db_flat must be held stable from start until done. Only the captured lr is used; lr changes during the sweep have no effect.
- Arithmetic per element, with g the gradient element and p the current parameter:
  - prod = lr*g, full 2*DATA_W signed product.
  - step = prod >>> FRAC_W (arithmetic shift, floor toward -inf, no rounding).
  - diff = p - step, computed at 2*DATA_W+1 bits.
  - Result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; there is no wrap-around.
- W_flat and b_flat reflect the registers directly. Each element changes only on its own update edge or load edge, so partially updated values are visible mid-sweep.

Test Plan:
- Reset, then load W[0][0]=0x0100 (1.0). Start with lr=0x0080 (0.5) and dW[0][0]=0x0080 (0.5) -> W[0][0]=0x00C0 (0.75) at edge k+1. Other W with dW=0 stay unchanged.
- Saturation: W=0x7F00, dW=0x8000, lr=0x0100 -> W=0x7FFF. Also W=0x8100, dW=0x7FFF, lr=0x0100 -> W=0x8000.
- Floor rounding: lr=0x0001, dW=0x0001 -> W unchanged. dW=0xFFFF -> W increments by 1.
- Timing with ROWS=4, COLS=4, start at edge k:
  - busy = 1 after edge k.
  - b[3] is written at edge k+20.
  - done is high during the single cycle after edge k+21.
  - busy = 0 after edge k+22.
  - start pulses at k+5 and k+10 are ignored, and the final values match a single sweep.
- Loads: load_en during busy -> target unchanged. start and load_en in the same IDLE cycle -> sweep runs and the load is dropped. load_addr = ROWS*COLS+ROWS -> no register changes.
- Reset mid-sweep (edge k+7) -> all W, b, busy and done are 0 on the next cycle. A subsequent start performs a full sweep from idx 0.
